// File: rtl/mc_arb_pkg.sv
// mc_arb_pkg: shared constants, FSM state type and one-hot helper for mc_share_arbiter
package mc_arb_pkg;
  localparam int MC_W = 4;
  typedef enum logic {IDLE, CMP} state_t;
  function automatic logic [7:0] onehot(input logic [2:0] id);
    return 8'b1 << id;
  endfunction
endpackage

// File: rtl/four_bit_mc_df.sv
// four_bit_mc_df: 4-bit unsigned magnitude comparator, dataflow style
module four_bit_mc_df (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);
  assign gt = a > b;
  assign eq = a == b;
  assign lt = a < b;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational winner select; round-robin from rr_ptr+1, or fixed lowest-index priority when MC_ARB_FIXED_PRIO_EN is defined
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             any_req,
  output logic [ID_W-1:0]  winner
);
  logic [ID_W-1:0] w_idx;
  assign any_req = |req;
  // scan from the lowest-priority candidate up so the highest-priority requester is written last
  always_comb begin
    winner = '0;
    w_idx  = '0;
`ifdef MC_ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) if (req[i]) winner = ID_W'(i);
`else
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (req[w_idx]) winner = w_idx;
    end
`endif
  end
endmodule

// File: rtl/mc_share_arbiter.sv
// mc_share_arbiter: shares one four_bit_mc_df among N_REQ req/ack clients; MC_ARB_FIXED_PRIO_EN selects fixed priority
module mc_share_arbiter
  import mc_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [4*N_REQ-1:0] a_bus,
  input  logic [4*N_REQ-1:0] b_bus,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic               resp_valid,
  output logic [ID_W-1:0]    resp_id,
  output logic               resp_gt,
  output logic               resp_eq,
  output logic               resp_lt
);
  state_t            r_state, w_next;
  logic [MC_W-1:0]   r_op_a, r_op_b;
  logic [ID_W-1:0]   r_gnt, r_rr_ptr, r_id, w_win;
  logic [N_REQ-1:0]  r_ack;
  logic              r_busy, r_valid, r_gt, r_eq, r_lt;
  logic              w_any, w_gt, w_eq, w_lt;
  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req(req), .rr_ptr(r_rr_ptr), .any_req(w_any), .winner(w_win)
  );
  four_bit_mc_df u_cmp (.a(r_op_a), .b(r_op_b), .gt(w_gt), .eq(w_eq), .lt(w_lt));
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // a grant always takes exactly one compare cycle
  always_comb w_next = (r_state == IDLE && w_any) ? CMP : IDLE;
  // grant capture in IDLE, result registration in CMP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_gt     <= 1'b0;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_gnt    <= '0;
      r_rr_ptr <= ID_W'(N_REQ - 1);
    end else if (r_state == IDLE) begin
      r_valid <= 1'b0;
      r_ack   <= w_any ? N_REQ'(onehot(3'(w_win))) : '0;
      r_busy  <= w_any;
      if (w_any) begin
        r_op_a <= a_bus[{w_win, 2'b00} +: MC_W];
        r_op_b <= b_bus[{w_win, 2'b00} +: MC_W];
        r_gnt  <= w_win;
`ifndef MC_ARB_FIXED_PRIO_EN
        r_rr_ptr <= w_win;
`endif
      end
    end else begin
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b1;
      r_id    <= r_gnt;
      r_gt    <= w_gt;
      r_eq    <= w_eq;
      r_lt    <= w_lt;
    end
  end
  assign ack        = r_ack;
  assign busy       = r_busy;
  assign resp_valid = r_valid;
  assign resp_id    = r_id;
  assign resp_gt    = r_gt;
  assign resp_eq    = r_eq;
  assign resp_lt    = r_lt;
endmodule

// File: tb/tb_mc_share_arbiter.sv
// tb_mc_share_arbiter: directed plus randomized checks against a transaction-level reference model
module tb_mc_share_arbiter;
  localparam int N = 4;
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [4*N-1:0] a_bus, b_bus;
  logic [N-1:0]   ack;
  logic           busy, resp_valid, resp_gt, resp_eq, resp_lt;
  logic [1:0]     resp_id;
  logic [3:0]     opa[N];
  logic [3:0]     opb[N];
  int n_chk = 0;
  int n_err = 0;
  int m_fly = -1;
  int m_ptr = N - 1;
  logic [3:0] m_a, m_b;
  logic [N-1:0] e_ack = '0;
  logic e_busy = 0, e_valid = 0, e_gt = 0, e_eq = 0, e_lt = 0;
  int e_id = 0;
  int d_q[$];
  int exp_order[5];

  mc_share_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .ack(ack), .busy(busy), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_gt(resp_gt), .resp_eq(resp_eq), .resp_lt(resp_lt)
  );

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < N; i++) begin
      a_bus[4*i +: 4] = opa[i];
      b_bus[4*i +: 4] = opb[i];
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef MC_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (rst) begin
      m_fly = -1; m_ptr = N - 1;
      e_ack = '0; e_busy = 0; e_valid = 0; e_id = 0; e_gt = 0; e_eq = 0; e_lt = 0;
    end else if (m_fly >= 0) begin
      e_valid = 1; e_id = m_fly;
      e_gt = m_a > m_b; e_eq = m_a == m_b; e_lt = m_a < m_b;
      e_ack = '0; e_busy = 0; m_fly = -1;
    end else begin
      w = pick(req, m_ptr);
      e_valid = 0; e_ack = '0; e_busy = 0;
      if (w >= 0) begin
        m_fly = w; m_a = opa[w]; m_b = opb[w];
        e_ack[w] = 1'b1; e_busy = 1;
`ifndef MC_ARB_FIXED_PRIO_EN
        m_ptr = w;
`endif
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("ack", 32'(ack), 32'(e_ack));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("resp_valid", 32'(resp_valid), 32'(e_valid));
    chk("resp_id", 32'(resp_id), 32'(e_id));
    chk("resp_gt", 32'(resp_gt), 32'(e_gt));
    chk("resp_eq", 32'(resp_eq), 32'(e_eq));
    chk("resp_lt", 32'(resp_lt), 32'(e_lt));
    if (resp_valid) chk("resp_onehot", 32'($countones({resp_gt, resp_eq, resp_lt})), 1);
    for (int i = 0; i < N; i++) if (ack[i]) d_q.push_back(i);
  endtask

  function automatic logic [3:0] rnd_op();
    int s = $urandom_range(0, 3);
    return s == 0 ? 4'd0 : s == 1 ? 4'd15 : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    rst = 1; req = '0;
    cycle(); cycle();
    rst = 0;
    cycle();
    // single requester, gt
    req = 4'b0001; opa[0] = 8; opb[0] = 3;
    cycle();
    chk("t1_ack", 32'(ack), 32'b0001);
    req = '0;
    cycle();
    chk("t1_valid", 32'(resp_valid), 1);
    chk("t1_gt", 32'(resp_gt), 1);
    // eq then lt, two grants two cycles apart
    req = 4'b0010; opa[1] = 9; opb[1] = 9;
    cycle();
    req = 4'b0100; opa[2] = 5; opb[2] = 7;
    cycle();
    chk("t2_eq", 32'(resp_eq), 1);
    cycle();
    req = '0;
    cycle();
    chk("t2_lt_id", 32'(resp_id), 2);
    chk("t2_lt", 32'(resp_lt), 1);
    // all requesters active from reset
    rst = 1; req = 4'b1111;
    for (int i = 0; i < N; i++) begin opa[i] = rnd_op(); opb[i] = rnd_op(); end
    opa[3] = 15; opb[3] = 4;
    cycle();
    rst = 0;
    d_q.delete();
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (resp_valid && resp_id == 2'd3) chk("t3_id3_gt", 32'(resp_gt), 1);
    end
`ifdef MC_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    chk("t3_ngrants", 32'(d_q.size()), 5);
    for (int k = 0; k < 5 && k < d_q.size(); k++) chk("t3_order", 32'(d_q[k]), 32'(exp_order[k]));
    // wrap after id 3
    req = 4'b1000;
    cycle();
    req = 4'b1001;
    cycle();
    cycle();
    chk("t4_wrap", 32'(ack), 32'b0001);
    req = '0;
    cycle(); cycle();
    // reset during CMP drops the in-flight request
    req = 4'b0001; opa[0] = 1; opb[0] = 0;
    cycle();
    rst = 1; req = '0;
    cycle();
    chk("t5_rst_valid", 32'(resp_valid), 0);
    rst = 0;
    cycle();
    chk("t5_rst_busy", 32'(busy), 0);
    req = 4'b0001;
    cycle();
    req = '0;
    cycle();
    chk("t5_rereq_gt", 32'(resp_gt), 1);
    // randomized traffic obeying the requester rules
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++)
        if (!(req[i] && !e_ack[i])) begin
          req[i] = ($urandom_range(0, 2) == 0);
          opa[i] = rnd_op();
          opb[i] = rnd_op();
        end
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
